// File: rtl/lopd_pipe.sv
// Pipelined leading-one position detector (byte-grouped scan, then group select), valid/ready elastic stages.
// Optional LOPD_SHIFT_OUT_EN adds o_norm_data = i_data << o_pos_one, computed in the final stage.
module lopd_pipe #(
    parameter int SIZE_DATA  = 32,
    parameter int SIZE_POS   = $clog2(SIZE_DATA),
    parameter int SIZE_TAG   = 8,
    parameter int NUM_STAGES = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_valid,
    output logic                 o_ready,
    input  logic [SIZE_DATA-1:0] i_data,
    input  logic [SIZE_TAG-1:0]  i_tag,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic [SIZE_POS-1:0]  o_pos_one,
    output logic                 o_zero_flag,
    output logic [SIZE_TAG-1:0]  o_tag
`ifdef LOPD_SHIFT_OUT_EN
    ,
    output logic [SIZE_DATA-1:0] o_norm_data
`endif
);
    localparam int NG = SIZE_DATA / 8;

    logic [NG-1:0][2:0]  in_lpos;
    logic [NG-1:0]       in_nz;

    logic                fd_valid;
    logic [NG-1:0][2:0]  fd_lpos;
    logic [NG-1:0]       fd_nz;
    logic [SIZE_TAG-1:0] fd_tag;
`ifdef LOPD_SHIFT_OUT_EN
    logic [SIZE_DATA-1:0] fd_data;
    logic [SIZE_DATA-1:0] out_norm;
`endif

    logic                out_valid;
    logic                out_load;
    logic [SIZE_POS-1:0] out_pos;
    logic                out_zero;
    logic [SIZE_TAG-1:0] out_tag;
    logic [SIZE_POS-1:0] sel_pos;
    logic                sel_zero;

    assign out_load = !out_valid || i_ready;

    // Group 0 is the most significant byte; local position counts from the byte's MSB.
    always_comb begin
        in_lpos = '0;
        in_nz   = '0;
        for (int g = 0; g < NG; g++) begin
            in_nz[g] = |i_data[SIZE_DATA-1-8*g -: 8];
            for (int i = 0; i < 8; i++) begin
                if (i_data[SIZE_DATA-8-8*g+i]) in_lpos[g] = 3'(7 - i);
            end
        end
    end

    generate
        if (NUM_STAGES == 2) begin : g_two
            logic                s0_valid;
            logic [NG-1:0][2:0]  s0_lpos;
            logic [NG-1:0]       s0_nz;
            logic [SIZE_TAG-1:0] s0_tag;
`ifdef LOPD_SHIFT_OUT_EN
            logic [SIZE_DATA-1:0] s0_data;
`endif
            always_ff @(posedge i_clk) begin
                if (!i_rst_n) begin
                    s0_valid <= 1'b0;
                    s0_lpos  <= '0;
                    s0_nz    <= '0;
                    s0_tag   <= '0;
`ifdef LOPD_SHIFT_OUT_EN
                    s0_data  <= '0;
`endif
                end else if (!s0_valid || out_load) begin
                    s0_valid <= i_valid;
                    if (i_valid) begin
                        s0_lpos <= in_lpos;
                        s0_nz   <= in_nz;
                        s0_tag  <= i_tag;
`ifdef LOPD_SHIFT_OUT_EN
                        s0_data <= i_data;
`endif
                    end
                end
            end

            assign o_ready  = i_rst_n && (!s0_valid || out_load);
            assign fd_valid = s0_valid;
            assign fd_lpos  = s0_lpos;
            assign fd_nz    = s0_nz;
            assign fd_tag   = s0_tag;
`ifdef LOPD_SHIFT_OUT_EN
            assign fd_data  = s0_data;
`endif
        end else begin : g_one
            assign o_ready  = i_rst_n && out_load;
            assign fd_valid = i_valid;
            assign fd_lpos  = in_lpos;
            assign fd_nz    = in_nz;
            assign fd_tag   = i_tag;
`ifdef LOPD_SHIFT_OUT_EN
            assign fd_data  = i_data;
`endif
        end
    endgenerate

    // Walk from the LSB group upward so the most significant nonzero group wins.
    always_comb begin
        sel_pos = '0;
        for (int g = NG - 1; g >= 0; g--) begin
            if (fd_nz[g]) sel_pos = SIZE_POS'(8 * g) + SIZE_POS'(fd_lpos[g]);
        end
    end

    assign sel_zero = ~|fd_nz;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            out_valid <= 1'b0;
            out_pos   <= '0;
            out_zero  <= 1'b0;
            out_tag   <= '0;
`ifdef LOPD_SHIFT_OUT_EN
            out_norm  <= '0;
`endif
        end else if (out_load) begin
            out_valid <= fd_valid;
            if (fd_valid) begin
                out_pos  <= sel_pos;
                out_zero <= sel_zero;
                out_tag  <= fd_tag;
`ifdef LOPD_SHIFT_OUT_EN
                out_norm <= fd_data << sel_pos;
`endif
            end
        end
    end

    assign o_valid     = out_valid;
    assign o_pos_one   = out_pos;
    assign o_zero_flag = out_zero;
    assign o_tag       = out_tag;
`ifdef LOPD_SHIFT_OUT_EN
    assign o_norm_data = out_norm;
`endif

endmodule

// File: tb/tb_lopd_pipe.sv
// Randomised and directed bench for lopd_pipe against an in-order queue model of the leading-one rule.
module tb_lopd_pipe #(
    parameter int SD = 32,
    parameter int NS = 2,
    parameter int ST = 8
);
    localparam int SP = $clog2(SD);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_valid;
    logic          o_ready;
    logic [SD-1:0] i_data;
    logic [ST-1:0] i_tag;
    logic          o_valid;
    logic          i_ready;
    logic [SP-1:0] o_pos;
    logic          o_zero;
    logic [ST-1:0] o_tag;
`ifdef LOPD_SHIFT_OUT_EN
    logic [SD-1:0] o_norm;
`endif

    always #5 clk = ~clk;

    lopd_pipe #(.SIZE_DATA(SD), .SIZE_TAG(ST), .NUM_STAGES(NS)) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_data      (i_data),
        .i_tag       (i_tag),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_pos_one   (o_pos),
        .o_zero_flag (o_zero),
        .o_tag       (o_tag)
`ifdef LOPD_SHIFT_OUT_EN
        ,
        .o_norm_data (o_norm)
`endif
    );

    typedef struct {
        logic [SD-1:0] d;
        logic [ST-1:0] t;
        int            acc;
        int            lit;
        bit            seen;
    } beat_t;

    beat_t         q[$];
    int            n_cmp = 0;
    int            n_bad = 0;
    int            cyc = 0;
    int            cur_lit = -1;
    bit            rst_prev = 1'b0;
    bit            chk_lat = 1'b0;
    bit            rr = 1'b0;
    bit            stall_prev = 1'b0;
    logic [SP-1:0] sv_pos;
    logic          sv_zero;
    logic [ST-1:0] sv_tag;
    logic [SD-1:0] sv_norm;

    function automatic int ref_pos(input logic [SD-1:0] d);
        for (int i = SD - 1; i >= 0; i--) if (d[i]) return SD - 1 - i;
        return 0;
    endfunction

    function automatic logic [SD-1:0] rnd_data();
        logic [63:0]   r;
        logic [SD-1:0] d;
        r = {$urandom, $urandom};
        d = SD'(r) >> $urandom_range(0, SD - 1);
        if ($urandom_range(0, 15) == 0) d = '0;
        return d;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: bound expired or unexpected event", nm);
    endtask

    always @(posedge clk) begin
        cyc++;
        rst_prev = rst_n;
        if (!rst_n) q.delete();
    end

    always @(negedge clk) begin
        beat_t b;
        if (!rst_prev) begin
            chk("rst_valid", 64'(o_valid), 64'd0);
            chk("rst_pos", 64'(o_pos), 64'd0);
            chk("rst_zero", 64'(o_zero), 64'd0);
            chk("rst_tag", 64'(o_tag), 64'd0);
`ifdef LOPD_SHIFT_OUT_EN
            chk("rst_norm", 64'(o_norm), 64'd0);
`endif
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                chk("hold_valid", 64'(o_valid), 64'd1);
                chk("hold_pos", 64'(o_pos), 64'(sv_pos));
                chk("hold_zero", 64'(o_zero), 64'(sv_zero));
                chk("hold_tag", 64'(o_tag), 64'(sv_tag));
`ifdef LOPD_SHIFT_OUT_EN
                chk("hold_norm", 64'(o_norm), 64'(sv_norm));
`endif
            end
            if (o_valid) begin
                if (q.size() == 0) begin
                    fail("spurious_valid");
                end else begin
                    if (chk_lat && !q[0].seen) chk("latency", 64'(cyc - q[0].acc), 64'(NS));
                    q[0].seen = 1'b1;
                    if (i_ready) begin
                        b = q.pop_front();
                        chk("pos", 64'(o_pos), 64'(ref_pos(b.d)));
                        chk("zero", 64'(o_zero), 64'(b.d == '0));
                        chk("tag", 64'(o_tag), 64'(b.t));
`ifdef LOPD_SHIFT_OUT_EN
                        chk("norm", 64'(o_norm), 64'(b.d << ref_pos(b.d)));
                        if (b.d != '0) chk("norm_msb", 64'(o_norm[SD-1]), 64'd1);
`endif
                        if (b.lit >= 0) chk("walk_pos", 64'(o_pos), 64'(b.lit));
                    end
                end
            end
            stall_prev = o_valid && !i_ready;
            sv_pos  = o_pos;
            sv_zero = o_zero;
            sv_tag  = o_tag;
`ifdef LOPD_SHIFT_OUT_EN
            sv_norm = o_norm;
`else
            sv_norm = '0;
`endif
        end
        if (!rst_n) chk("rst_ready", 64'(o_ready), 64'd0);
        if (i_valid && o_ready)
            q.push_back('{d: i_data, t: i_tag, acc: cyc, lit: cur_lit, seen: 1'b0});
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rr) i_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1);
    end

    task automatic idle();
        i_valid = 1'b0;
        i_data  = rnd_data();
        i_tag   = ST'($urandom);
        cur_lit = -1;
    endtask

    task automatic push(input logic [SD-1:0] d, input logic [ST-1:0] t, input int lit);
        i_valid = 1'b1;
        i_data  = d;
        i_tag   = t;
        cur_lit = lit;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (o_ready) begin
                @(posedge clk);
                #1;
                idle();
                return;
            end
            @(posedge clk);
            #1;
        end
        fail("push_timeout");
        idle();
    endtask

    task automatic wait_empty();
        for (int k = 0; k < 200; k++) begin
            @(posedge clk);
            #1;
            if (q.size() == 0 && !o_valid) break;
        end
        chk("drain", 64'(q.size()), 64'd0);
    endtask

    task automatic run_cycles_accepting(input int n);
        bit fire;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            fire = o_ready;
            @(posedge clk);
            #1;
            if (fire) begin
                i_data = rnd_data();
                i_tag  = ST'($urandom);
            end
        end
    endtask

    initial begin : main
        logic [SD-1:0] one;
        logic [SD-1:0] m;
        int            n;
        bit            fire;

        rst_n   = 1'b0;
        i_ready = 1'b1;
        i_valid = 1'b1;
        i_data  = rnd_data();
        i_tag   = ST'($urandom);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("ready_after_rst", 64'(o_ready), 64'd1);
        @(posedge clk);
        #1;
        idle();

        // One-hot and one-hot-with-trailing-noise walk over every bit, then zero.
        chk_lat = 1'b1;
        one = 1;
        for (int b = SD - 1; b >= 0; b--) push(one << b, ST'(b), SD - 1 - b);
        for (int b = 0; b < SD; b++) begin
            m = (one << b) - one;
            push((one << b) | (rnd_data() & m), ST'(b + 64), SD - 1 - b);
        end
        push('0, ST'(8'hA5), 0);
        wait_empty();
        chk_lat = 1'b0;

        rr = 1'b1;
        n  = 0;
        for (int k = 0; k < 20000 && n < 1000; k++) begin
            if (!i_valid && $urandom_range(0, 3) != 0) begin
                i_valid = 1'b1;
                i_data  = rnd_data();
                i_tag   = ST'($urandom);
            end
            @(negedge clk);
            fire = i_valid && o_ready;
            @(posedge clk);
            #1;
            if (fire) begin
                n++;
                idle();
            end
        end
        chk("stream_count", 64'(n), 64'd1000);
        rr = 1'b0;
        i_ready = 1'b1;
        idle();
        wait_empty();

        // Fill under stall, then release: one accept and one result every cycle.
        i_ready = 1'b0;
        i_valid = 1'b1;
        i_data  = rnd_data();
        i_tag   = ST'($urandom);
        run_cycles_accepting(5);
        i_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            chk("conc_ready", 64'(o_ready), 64'd1);
            chk("conc_valid", 64'(o_valid), 64'd1);
            fire = o_ready;
            @(posedge clk);
            #1;
            if (fire) begin
                i_data = rnd_data();
                i_tag  = ST'($urandom);
            end
        end
        idle();
        wait_empty();

        // Reset with beats in flight: nothing may reappear afterwards.
        i_ready = 1'b0;
        i_valid = 1'b1;
        i_data  = rnd_data();
        i_tag   = ST'($urandom);
        run_cycles_accepting(3);
        rst_n = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        rst_n   = 1'b1;
        i_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("post_rst_valid", 64'(o_valid), 64'd0);
        for (int k = 0; k < 4; k++) push(rnd_data(), ST'($urandom), -1);
        wait_empty();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
